// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates the board's 8-channel, 12-bit serial ADC at the far end of the
// ADC SPI link. The reader drives SCLK/CS/DIN. This block answers with
// caller-supplied channel values, MSB first, and learns the channel
// address for the following frame from DIN. All SPI inputs are
// oversampled in the clk_50 domain.

module adc_spi_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_50,
  input  logic                  reset_n,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_din,
  output logic                  spi_dout,
  output logic                  spi_dout_oe,
  input  logic [8*DATA_W-1:0]   ch_data,
  output logic [2:0]            next_ch,
  output logic                  frame_done,
  output logic                  frame_err
);

  // Frame geometry: leading zeros followed by the conversion result.
  localparam int FRAME_LEN = DATA_W + LEAD_ZEROS;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  // Rising-edge numbers on which the three address bits arrive (ADD2 first).
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ADD2  = CNT_W'(3);
  localparam logic [CNT_W-1:0] CNT_ADD1  = CNT_W'(4);
  localparam logic [CNT_W-1:0] CNT_ADD0  = CNT_W'(5);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  // Synchronizer chains; the last stage is the usable value.
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_din_sync;

  // Previous synchronized values for edge detection.
  logic r_sclk_prev;
  logic r_cs_prev;

  // Tracks how long since reset so that reset values of the synchronizer
  // are not mistaken for real pin samples.
  logic [SYNC_STAGES:0] r_prime;
  logic                 r_cs_armed;

  // Frame state and datapath.
  state_t                 r_state;
  state_t                 w_next_state;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [CNT_W-1:0]       r_rise_cnt;
  logic [CNT_W-1:0]       w_rise_next;
  logic [2:0]             r_addr_cap;
  logic [2:0]             r_next_ch;
  logic                   r_frame_done;
  logic                   r_frame_err;

  // Combinational helpers.
  logic              w_sclk_s;
  logic              w_cs_s;
  logic              w_din_s;
  logic              w_sclk_rise;
  logic              w_sclk_fall;
  logic              w_cs_rise;
  logic              w_cs_fall;
  logic              w_primed;
  logic              w_done_set;
  logic              w_err_set;
  logic              w_dout;
  logic              w_oe;
  logic [DATA_W-1:0] w_sel_data;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_din_s     = r_din_sync[SYNC_STAGES-1];
  assign w_sclk_rise =  w_sclk_s & ~r_sclk_prev;
  assign w_sclk_fall = ~w_sclk_s &  r_sclk_prev;
  assign w_cs_rise   =  w_cs_s   & ~r_cs_prev;
  assign w_cs_fall   = ~w_cs_s   &  r_cs_prev;
  assign w_primed    = r_prime[SYNC_STAGES];
  assign w_rise_next = r_rise_cnt + CNT_ONE;

  assign spi_dout    = w_dout;
  assign spi_dout_oe = w_oe;
  assign next_ch     = r_next_ch;
  assign frame_done  = r_frame_done;
  assign frame_err   = r_frame_err;

  // Bring the asynchronous SPI pins into clk_50; SCLK/CS idle high, DIN low.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_din_sync  <= '0;
      r_sclk_prev <= 1'b1;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sclk_sync <= (r_sclk_sync << 1) | SYNC_STAGES'(spi_clk);
      r_cs_sync   <= (r_cs_sync   << 1) | SYNC_STAGES'(spi_cs_n);
      r_din_sync  <= (r_din_sync  << 1) | SYNC_STAGES'(spi_din);
      r_sclk_prev <= w_sclk_s;
      r_cs_prev   <= w_cs_s;
    end
  end

  // Only accept a CS falling edge after CS has genuinely been seen high, so
  // a reset released with CS already low cannot start a frame.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_prime    <= '0;
      r_cs_armed <= 1'b0;
    end else begin
      r_prime    <= {r_prime[SYNC_STAGES-1:0], 1'b1};
      r_cs_armed <= r_cs_armed | (w_primed & w_cs_s);
    end
  end

  // Pick the channel that the upcoming frame will return.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < 8; k++) begin
      if (r_next_ch == 3'(k)) begin
        w_sel_data = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state, pulse requests and pin outputs for the frame sequencer.
  always_comb begin
    w_next_state = r_state;
    w_done_set   = 1'b0;
    w_err_set    = 1'b0;
    w_dout       = 1'b0;
    w_oe         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cs_fall && r_cs_armed) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_cs_rise) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_dout = r_shift[FRAME_LEN-1];
        w_oe   = 1'b1;
        if (r_rise_cnt == CNT_FULL) begin
          // A complete frame wins even if CS rose alongside the last edge.
          w_done_set   = 1'b1;
          w_next_state = S_DONE;
        end else if (w_cs_rise) begin
          if (w_sclk_rise && (r_rise_cnt == CNT_LAST)) begin
            w_next_state = S_SHIFT;
          end else if (r_rise_cnt != CNT_ZERO) begin
            w_err_set    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_DONE: begin
        w_oe = 1'b1;
        // Level test so a CS rise that coincided with the last edge still
        // returns us to idle.
        if (w_cs_s) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Shift register, edge counter, address capture and completion pulses.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_shift      <= '0;
      r_rise_cnt   <= '0;
      r_addr_cap   <= '0;
      r_next_ch    <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_done <= w_done_set;
      r_frame_err  <= w_err_set;
      if (r_state == S_LOAD) begin
        r_shift    <= {{LEAD_ZEROS{1'b0}}, w_sel_data};
        r_rise_cnt <= '0;
        r_addr_cap <= '0;
      end else if (r_state == S_SHIFT) begin
        if (w_sclk_rise && (r_rise_cnt != CNT_FULL)) begin
          r_rise_cnt <= w_rise_next;
          if (w_rise_next == CNT_ADD2) begin
            r_addr_cap[2] <= w_din_s;
          end
          if (w_rise_next == CNT_ADD1) begin
            r_addr_cap[1] <= w_din_s;
          end
          if (w_rise_next == CNT_ADD0) begin
            r_addr_cap[0] <= w_din_s;
          end
        end
        if (w_sclk_fall && (r_rise_cnt != CNT_ZERO)) begin
          r_shift <= {r_shift[FRAME_LEN-2:0], 1'b0};
        end
        if (w_done_set) begin
          r_next_ch <= r_addr_cap;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder
// Plays the SoC's ADC reader against the responder and compares what it
// receives with a behavioural model: a table of channel values plus the
// channel the next full frame should return.

module tb_adc_spi_responder;

   logic        clk_50 = 1'b0;
   logic        reset_n;
   logic        spi_clk;
   logic        spi_cs_n;
   logic        spi_din;
   logic        spi_dout;
   logic        spi_dout_oe;
   logic [95:0] ch_data;
   logic [2:0]  next_ch;
   logic        frame_done;
   logic        frame_err;

   int checks = 0;
   int failures = 0;

   // Pulse bookkeeping gathered by a free-running monitor.
   int  doneCnt = 0;
   int  errCnt = 0;
   int  widePulses = 0;
   logic donePrev = 1'b0;
   logic errPrev = 1'b0;

   // Reference model: channel table and the channel the next frame returns.
   logic [11:0] chModel [8];
   int          expNextCh;

   logic [15:0] rxWord;
   logic [2:0]  addr;
   int          doneBase;
   int          errBase;

   adc_spi_responder #(
      .DATA_W(12),
      .LEAD_ZEROS(4),
      .SYNC_STAGES(2)
   ) dut (
      .clk_50(clk_50),
      .reset_n(reset_n),
      .spi_clk(spi_clk),
      .spi_cs_n(spi_cs_n),
      .spi_din(spi_din),
      .spi_dout(spi_dout),
      .spi_dout_oe(spi_dout_oe),
      .ch_data(ch_data),
      .next_ch(next_ch),
      .frame_done(frame_done),
      .frame_err(frame_err)
   );

   // 50 MHz system clock.
   always #10 clk_50 = ~clk_50;

   // Count completion/error pulses and flag any that last longer than a cycle.
   always @(posedge clk_50) begin
      if (frame_done) doneCnt++;
      if (frame_err) errCnt++;
      if ((frame_done && donePrev) || (frame_err && errPrev)) widePulses++;
      donePrev = frame_done;
      errPrev = frame_err;
   end

   // Safety net so the run always ends even if something wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit expired");
      $fatal(1, "[TB] watchdog");
   end

   // Advance n system clocks, landing just after the active edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_50);
         #1;
      end
   endtask

   // Push the model's channel table onto the ch_data bus.
   task automatic driveChannels();
      for (int k = 0; k < 8; k++) ch_data[12*k +: 12] = chModel[k];
   endtask

   // Compare one observed value against the model's expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Act as the reader: drop CS, clock nRises SCLK cycles (8 clk_50 per
   // phase), put the address on DIN for rises 3..5 and random junk
   // elsewhere, and sample spi_dout at each rising edge. Optionally rewrite
   // channel 0 at rise chgAt, or raise CS together with the final rise.
   task automatic applyStimulus(input logic [2:0] a, input int nRises, input int chgAt,
                                input logic [11:0] chgVal, input bit csWithLast,
                                output logic [15:0] rx);
      rx = '0;
      spi_cs_n = 1'b0;
      tick(8);
      for (int k = 1; k <= nRises; k++) begin
         spi_clk = 1'b0;
         if (k == 3) spi_din = a[2];
         else if (k == 4) spi_din = a[1];
         else if (k == 5) spi_din = a[0];
         else spi_din = 1'($urandom);
         tick(8);
         rx[16-k] = spi_dout;
         spi_clk = 1'b1;
         if (csWithLast && k == nRises) spi_cs_n = 1'b1;
         if (k == chgAt) ch_data[11:0] = chgVal;
         tick(8);
      end
   endtask

   // Reader ends the transfer.
   task automatic csRise();
      spi_cs_n = 1'b1;
      spi_din = 1'b0;
      tick(8);
   endtask

   // Directed sequence with randomized channel data and addresses.
   initial begin
      reset_n = 1'b0;
      spi_clk = 1'b1;
      spi_cs_n = 1'b1;
      spi_din = 1'b0;
      for (int k = 0; k < 8; k++) chModel[k] = 12'($urandom);
      chModel[0] = 12'hABC;
      driveChannels();
      expNextCh = 0;
      tick(3);
      reset_n = 1'b1;
      tick(10);

      // Reset and idle.
      checkOutput("idle_dout", 32'(spi_dout), 32'd0);
      checkOutput("idle_oe", 32'(spi_dout_oe), 32'd0);
      checkOutput("idle_next_ch", 32'(next_ch), 32'd0);
      checkOutput("idle_done_cnt", 32'(doneCnt), 32'd0);
      checkOutput("idle_err_cnt", 32'(errCnt), 32'd0);

      // First frame returns channel 0 and carries address 3.
      doneBase = doneCnt;
      errBase = errCnt;
      applyStimulus(3'd3, 16, 0, 12'h0, 1'b0, rxWord);
      checkOutput("f1_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
      checkOutput("f1_oe_done", 32'(spi_dout_oe), 32'd1);
      checkOutput("f1_dout_done", 32'(spi_dout), 32'd0);
      csRise();
      expNextCh = 3;
      checkOutput("f1_done_pulses", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("f1_err_pulses", 32'(errCnt - errBase), 32'd0);
      checkOutput("f1_next_ch", 32'(next_ch), 32'(expNextCh));
      checkOutput("f1_oe_after", 32'(spi_dout_oe), 32'd0);

      // Back-to-back: ch3=0x123 with address 7, then ch7=0xFFF.
      chModel[3] = 12'h123;
      chModel[7] = 12'hFFF;
      driveChannels();
      applyStimulus(3'd7, 16, 0, 12'h0, 1'b0, rxWord);
      csRise();
      checkOutput("f2_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
      expNextCh = 7;
      checkOutput("f2_next_ch", 32'(next_ch), 32'(expNextCh));
      addr = 3'($urandom_range(0, 7));
      applyStimulus(addr, 16, 0, 12'h0, 1'b0, rxWord);
      csRise();
      checkOutput("f3_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
      expNextCh = int'(addr);
      checkOutput("f3_next_ch", 32'(next_ch), 32'(expNextCh));

      // A run of random frames with fresh channel data each time.
      for (int f = 0; f < 4; f++) begin
         chModel[expNextCh] = 12'($urandom);
         driveChannels();
         addr = 3'($urandom_range(0, 7));
         doneBase = doneCnt;
         applyStimulus(addr, 16, 0, 12'h0, 1'b0, rxWord);
         csRise();
         checkOutput("rand_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
         expNextCh = int'(addr);
         checkOutput("rand_next_ch", 32'(next_ch), 32'(expNextCh));
         checkOutput("rand_done_pulses", 32'(doneCnt - doneBase), 32'd1);
      end

      // Set up next_ch=3, then abort a frame after 8 rising edges.
      applyStimulus(3'd3, 16, 0, 12'h0, 1'b0, rxWord);
      csRise();
      expNextCh = 3;
      doneBase = doneCnt;
      errBase = errCnt;
      applyStimulus(3'($urandom_range(0, 7)), 8, 0, 12'h0, 1'b0, rxWord);
      csRise();
      checkOutput("abort_err_pulses", 32'(errCnt - errBase), 32'd1);
      checkOutput("abort_done_pulses", 32'(doneCnt - doneBase), 32'd0);
      checkOutput("abort_next_ch", 32'(next_ch), 32'(expNextCh));
      checkOutput("abort_oe", 32'(spi_dout_oe), 32'd0);
      applyStimulus(3'd0, 16, 0, 12'h0, 1'b0, rxWord);
      csRise();
      checkOutput("after_abort_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
      expNextCh = 0;

      // Channel 0 rewritten mid-frame: the frame keeps the value loaded at start.
      chModel[0] = 12'hABC;
      driveChannels();
      applyStimulus(3'd5, 16, 6, 12'h555, 1'b0, rxWord);
      csRise();
      checkOutput("frozen_rx", 32'(rxWord), 32'h0ABC);
      chModel[0] = 12'h555;
      expNextCh = 5;
      checkOutput("frozen_next_ch", 32'(next_ch), 32'(expNextCh));

      // CS rises together with the 16th rising edge: still a completed frame.
      doneBase = doneCnt;
      errBase = errCnt;
      addr = 3'($urandom_range(0, 7));
      applyStimulus(addr, 16, 0, 12'h0, 1'b1, rxWord);
      tick(8);
      checkOutput("simul_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
      checkOutput("simul_done_pulses", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("simul_err_pulses", 32'(errCnt - errBase), 32'd0);
      expNextCh = int'(addr);
      checkOutput("simul_next_ch", 32'(next_ch), 32'(expNextCh));
      checkOutput("simul_oe", 32'(spi_dout_oe), 32'd0);

      // Reset asserted at rising edge 10 with CS held low.
      errBase = errCnt;
      applyStimulus(3'd2, 10, 0, 12'h0, 1'b0, rxWord);
      reset_n = 1'b0;
      #1;
      expNextCh = 0;
      checkOutput("rst_dout", 32'(spi_dout), 32'd0);
      checkOutput("rst_oe", 32'(spi_dout_oe), 32'd0);
      checkOutput("rst_next_ch", 32'(next_ch), 32'(expNextCh));
      checkOutput("rst_done", 32'(frame_done), 32'd0);
      checkOutput("rst_err", 32'(frame_err), 32'd0);
      tick(3);
      reset_n = 1'b1;
      tick(20);
      checkOutput("rst_cs_low_no_frame", 32'(spi_dout_oe), 32'd0);
      csRise();
      doneBase = doneCnt;
      addr = 3'($urandom_range(0, 7));
      applyStimulus(addr, 16, 0, 12'h0, 1'b0, rxWord);
      csRise();
      checkOutput("post_rst_rx", 32'(rxWord), {20'h0, 4'h0, chModel[expNextCh]});
      checkOutput("post_rst_done_pulses", 32'(doneCnt - doneBase), 32'd1);
      checkOutput("post_rst_err_pulses", 32'(errCnt - errBase), 32'd0);
      expNextCh = int'(addr);
      checkOutput("post_rst_next_ch", 32'(next_ch), 32'(expNextCh));

      // Every pulse seen during the run was a single cycle wide.
      checkOutput("pulse_width", 32'(widePulses), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
